// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared definitions for the seven-segment display controller:
//               source tags for the `showing` output, controller FSM states,
//               value widths and the BCD clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int BIN_W = 14;
    localparam int BCD_W = 16;

    // Source tags reported on `showing`
    localparam logic [1:0] SRC_SCORE = 2'b00;
    localparam logic [1:0] SRC_TIMER = 2'b01;
    localparam logic [1:0] SRC_ALERT = 2'b10;

    // Largest value that fits in four BCD digits
    localparam logic [BIN_W-1:0] BCD_MAX = 14'd9999;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Saturate a 14-bit binary value into the displayable range
    function automatic logic [BIN_W-1:0] clamp_bcd(input logic [BIN_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble converter, one shift per clock.
//               A `start` pulse loads `bin`; fourteen adjust-and-shift steps
//               follow. `done` is high during the final step, and the digit
//               outputs hold the finished result from the next cycle until
//               the following `start`.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start, bin      - load request and 14-bit binary operand
//               done            - high in the last conversion cycle
//               ones..thousands - BCD result nibbles
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands
);

    localparam int c_SR_W = BCD_W + BIN_W;

    logic [c_SR_W-1:0] r_shift;
    logic [c_SR_W-1:0] w_adj;
    logic [3:0]        r_cnt;
    logic              r_busy;

    // Add 3 to every BCD nibble that is 5 or more before shifting
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < 4; i++) begin
            if (w_adj[BIN_W + 4*i +: 4] >= 4'd5) begin
                w_adj[BIN_W + 4*i +: 4] = w_adj[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
        end else if (start) begin
            r_shift <= {{BCD_W{1'b0}}, bin};
            r_cnt   <= 4'(BIN_W);
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_shift <= {w_adj[c_SR_W-2:0], 1'b0};
            r_cnt   <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign done      = r_busy && (r_cnt == 4'd1);
    assign ones      = r_shift[BIN_W +: 4];
    assign tens      = r_shift[BIN_W + 4 +: 4];
    assign hundreds  = r_shift[BIN_W + 8 +: 4];
    assign thousands = r_shift[BIN_W + 12 +: 4];

endmodule
`default_nettype wire

// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_ctrl
// Description : Shares a 4-digit seven-segment display between score, timer
//               and a handshaked alert, converts the selected value to BCD
//               with a sequential converter and generates the 250 Hz
//               multiplex refresh clock.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               score, timer        - 14-bit binary sources, always valid
//               auto_rotate,src_sel - automatic alternation / manual select
//               alert_req,alert_val - alert request level and value
//               alert_ack           - one-cycle acceptance pulse
//               clk_250Hz           - registered 50% duty refresh clock
//               ones..thousands     - committed BCD digits
//               showing             - source tag of the committed digits
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int ALERT_MS  = 2000,
    parameter int ROTATE_MS = 3000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] score,
    input  logic [BIN_W-1:0] timer,
    input  logic             auto_rotate,
    input  logic             src_sel,
    input  logic             alert_req,
    input  logic [BIN_W-1:0] alert_val,
    output logic             alert_ack,
    output logic             clk_250Hz,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands,
    output logic [1:0]       showing
);

    localparam int c_REF_DIV = CLK_HZ / 500;
    localparam int c_MS_DIV  = CLK_HZ / 1000;
    localparam int c_REF_W   = (c_REF_DIV > 1) ? $clog2(c_REF_DIV) : 1;
    localparam int c_MS_W    = (c_MS_DIV  > 1) ? $clog2(c_MS_DIV)  : 1;
    localparam int c_ROT_W   = (ROTATE_MS > 1) ? $clog2(ROTATE_MS) : 1;
    localparam int c_HOLD_W  = (ALERT_MS  > 1) ? $clog2(ALERT_MS)  : 1;

    localparam logic [c_REF_W-1:0]  c_REF_LAST  = c_REF_W'(c_REF_DIV - 1);
    localparam logic [c_MS_W-1:0]   c_MS_LAST   = c_MS_W'(c_MS_DIV - 1);
    localparam logic [c_ROT_W-1:0]  c_ROT_LAST  = c_ROT_W'(ROTATE_MS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(ALERT_MS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_start;
    logic                w_commit;
    logic                w_accept;
    logic                w_done;

    logic [c_REF_W-1:0]  r_ref_cnt;
    logic                r_clk_250;
    logic [c_MS_W-1:0]   r_ms_cnt;
    logic                w_ms_tick;
    logic [c_ROT_W-1:0]  r_rot_cnt;
    logic                r_rot_src;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_alert_active;
    logic [BIN_W-1:0]    r_alert_val;

    logic [BIN_W-1:0]    w_raw;
    logic [1:0]          w_tag;
    logic [1:0]          r_tag;

    logic [3:0]          w_bcd_ones;
    logic [3:0]          w_bcd_tens;
    logic [3:0]          w_bcd_hundreds;
    logic [3:0]          w_bcd_thousands;
    logic [3:0]          r_ones;
    logic [3:0]          r_tens;
    logic [3:0]          r_hundreds;
    logic [3:0]          r_thousands;
    logic [1:0]          r_showing;

    // ------------------------------------------------------------------
    // Prescalers
    // ------------------------------------------------------------------
    assign w_ms_tick = (r_ms_cnt == c_MS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt <= '0;
            r_clk_250 <= 1'b0;
            r_ms_cnt  <= '0;
        end else begin
            if (r_ref_cnt == c_REF_LAST) begin
                r_ref_cnt <= '0;
                r_clk_250 <= ~r_clk_250;
            end else begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end
            r_ms_cnt <= w_ms_tick ? '0 : r_ms_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Score/timer rotation; leaving auto mode parks the counter at 0 so a
    // later re-entry starts a full period.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rot_cnt <= '0;
            r_rot_src <= 1'b0;
        end else if (!auto_rotate) begin
            r_rot_cnt <= '0;
            r_rot_src <= src_sel;
        end else if (w_ms_tick) begin
            if (r_rot_cnt == c_ROT_LAST) begin
                r_rot_cnt <= '0;
                r_rot_src <= ~r_rot_src;
            end else begin
                r_rot_cnt <= r_rot_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Alert hold. Acceptance only looks at the current active flag, so an
    // expiry and a waiting request in the same cycle resolve as expiry
    // first, acceptance at the next LOAD.
    // ------------------------------------------------------------------
    assign w_accept  = (r_state == ST_LOAD) && alert_req && !r_alert_active && !rst;
    assign alert_ack = w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alert_active <= 1'b0;
            r_hold_cnt     <= '0;
            r_alert_val    <= '0;
        end else if (w_accept) begin
            r_alert_active <= 1'b1;
            r_hold_cnt     <= '0;
            r_alert_val    <= alert_val;
        end else if (r_alert_active && w_ms_tick) begin
            if (r_hold_cnt == c_HOLD_LAST) begin
                r_alert_active <= 1'b0;
                r_hold_cnt     <= '0;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Source arbitration: new alert, held alert, then rotation source
    // ------------------------------------------------------------------
    always_comb begin
        w_raw = r_rot_src ? timer : score;
        w_tag = r_rot_src ? SRC_TIMER : SRC_SCORE;
        if (w_accept) begin
            w_raw = alert_val;
            w_tag = SRC_ALERT;
        end else if (r_alert_active) begin
            w_raw = r_alert_val;
            w_tag = SRC_ALERT;
        end
    end

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_start      = 1'b1;
                w_state_next = ST_CONV;
            end
            ST_CONV: begin
                if (w_done) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = ST_LOAD;
            end
            default: begin
                w_state_next = ST_LOAD;
            end
        endcase
    end

    bin2bcd_seq u_bin2bcd (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .bin       (clamp_bcd(w_raw)),
        .done      (w_done),
        .ones      (w_bcd_ones),
        .tens      (w_bcd_tens),
        .hundreds  (w_bcd_hundreds),
        .thousands (w_bcd_thousands)
    );

    // Digits and tag move together only in COMMIT, so the display never
    // sees an intermediate shift-register value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag       <= SRC_SCORE;
            r_ones      <= 4'd0;
            r_tens      <= 4'd0;
            r_hundreds  <= 4'd0;
            r_thousands <= 4'd0;
            r_showing   <= SRC_SCORE;
        end else begin
            if (w_start) begin
                r_tag <= w_tag;
            end
            if (w_commit) begin
                r_ones      <= w_bcd_ones;
                r_tens      <= w_bcd_tens;
                r_hundreds  <= w_bcd_hundreds;
                r_thousands <= w_bcd_thousands;
                r_showing   <= r_tag;
            end
        end
    end

    assign clk_250Hz = r_clk_250;
    assign ones      = r_ones;
    assign tens      = r_tens;
    assign hundreds  = r_hundreds;
    assign thousands = r_thousands;
    assign showing   = r_showing;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_ctrl
// Description : Self-checking bench for seg_display_ctrl. A cycle-indexed
//               reference model (update windows of 16 clocks, alert windows
//               as cycle ranges, rotation as a run-length count) predicts
//               every output; directed sequences plus random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_ctrl;

    localparam int CLK_HZ    = 1000;
    localparam int ALERT_MS  = 40;
    localparam int ROTATE_MS = 100;
    localparam int REF_DIV   = CLK_HZ / 500;
    localparam int PERIOD    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] score;
    logic [13:0] timer;
    logic        auto_rotate;
    logic        src_sel;
    logic        alert_req;
    logic [13:0] alert_val;
    logic        alert_ack;
    logic        clk_250Hz;
    logic [3:0]  ones;
    logic [3:0]  tens;
    logic [3:0]  hundreds;
    logic [3:0]  thousands;
    logic [1:0]  showing;

    seg_display_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .ALERT_MS  (ALERT_MS),
        .ROTATE_MS (ROTATE_MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .score       (score),
        .timer       (timer),
        .auto_rotate (auto_rotate),
        .src_sel     (src_sel),
        .alert_req   (alert_req),
        .alert_val   (alert_val),
        .alert_ack   (alert_ack),
        .clk_250Hz   (clk_250Hz),
        .ones        (ones),
        .tens        (tens),
        .hundreds    (hundreds),
        .thousands   (thousands),
        .showing     (showing)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int dut_acks = 0;

    // Reference model state
    int m_n;            // clocks since reset release
    int m_disp;         // value currently expected on the digits
    int m_show;         // tag currently expected on showing
    int m_pend_val;
    int m_pend_tag;
    bit m_alert_on;
    int m_alert_end;    // last LOAD-evaluation cycle the alert still holds
    int m_alert_latched;
    int m_rot_src;
    int m_auto_run;     // consecutive clocks spent in auto mode

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampv(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    task automatic model_reset();
        m_n         = 0;
        m_disp      = 0;
        m_show      = 0;
        m_pend_val  = 0;
        m_pend_tag  = 0;
        m_alert_on  = 1'b0;
        m_alert_end = 0;
        m_rot_src   = 0;
        m_auto_run  = 0;
    endtask

    // Called at a falling edge with inputs already applied; checks the
    // outputs for this cycle, advances the model past the next rising edge
    // and returns at the following falling edge.
    task automatic step(input bit r);
        bit active;
        int exp_ack;
        rst = r;
        #1;
        active  = m_alert_on && (m_n <= m_alert_end);
        exp_ack = (!r && (m_n % PERIOD == 0) && alert_req && !active) ? 1 : 0;
        check_val("clk_250Hz", int'(clk_250Hz), (m_n / REF_DIV) % 2);
        check_val("ones",      int'(ones),      m_disp % 10);
        check_val("tens",      int'(tens),      (m_disp / 10) % 10);
        check_val("hundreds",  int'(hundreds),  (m_disp / 100) % 10);
        check_val("thousands", int'(thousands), m_disp / 1000);
        check_val("showing",   int'(showing),   m_show);
        check_val("alert_ack", int'(alert_ack), exp_ack);
        if (alert_ack === 1'b1) dut_acks++;
        if (r) begin
            model_reset();
        end else begin
            if (m_n % PERIOD == 0) begin
                if (alert_req && !active) begin
                    m_alert_latched = int'(alert_val);
                    m_alert_on      = 1'b1;
                    m_alert_end     = m_n + ALERT_MS;
                    m_pend_val      = clampv(int'(alert_val));
                    m_pend_tag      = 2;
                end else if (active) begin
                    m_pend_val = clampv(m_alert_latched);
                    m_pend_tag = 2;
                end else begin
                    m_pend_val = clampv(m_rot_src ? int'(timer) : int'(score));
                    m_pend_tag = m_rot_src;
                end
            end
            if (m_n % PERIOD == PERIOD - 1) begin
                m_disp = m_pend_val;
                m_show = m_pend_tag;
            end
            if (auto_rotate) begin
                m_auto_run++;
                if (m_auto_run % ROTATE_MS == 0) m_rot_src = 1 - m_rot_src;
            end else begin
                m_auto_run = 0;
                m_rot_src  = int'(src_sel);
            end
            m_n++;
        end
        @(negedge clk);
    endtask

    function automatic int digits16();
        return int'({thousands, hundreds, tens, ones});
    endfunction

    initial begin
        int highs;
        score       = 14'd1234;
        timer       = 14'd0;
        auto_rotate = 1'b0;
        src_sel     = 1'b0;
        alert_req   = 1'b0;
        alert_val   = 14'd0;
        rst         = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check_val("rst_digits",  digits16(), 0);
        check_val("rst_showing", int'(showing), 0);
        check_val("rst_clk250",  int'(clk_250Hz), 0);

        // Score 1234 on manual select
        repeat (32) step(1'b0);
        check_val("score_1234", digits16(), 'h1234);
        check_val("score_tag",  int'(showing), 0);

        // Clamp above 9999
        score = 14'd12000;
        repeat (32) step(1'b0);
        check_val("clamp_9999", digits16(), 'h9999);

        // Refresh clock duty over two periods
        highs = 0;
        for (int i = 0; i < 2 * 2 * REF_DIV; i++) begin
            if (clk_250Hz === 1'b1) highs++;
            step(1'b0);
        end
        check_val("clk250_duty", highs, 2 * REF_DIV);

        // Automatic rotation between score 5 and timer 77
        score       = 14'd5;
        timer       = 14'd77;
        auto_rotate = 1'b1;
        repeat (2 * ROTATE_MS + 48) step(1'b0);

        // Held alert: one ack, expiry, second ack
        auto_rotate = 1'b0;
        step(1'b1);
        alert_req = 1'b1;
        alert_val = 14'd42;
        dut_acks  = 0;
        repeat (3 * PERIOD) step(1'b0);
        check_val("alert_0042", digits16(), 'h0042);
        check_val("alert_tag",  int'(showing), 2);
        repeat (3 * PERIOD) step(1'b0);
        check_val("alert_acks", dut_acks, 2);
        alert_req   = 1'b0;
        auto_rotate = 1'b1;
        repeat (ROTATE_MS + 64) step(1'b0);

        // Reset inside a conversion, then a clean update
        auto_rotate = 1'b0;
        score       = 14'd4321;
        step(1'b1);
        repeat (PERIOD + 7) step(1'b0);
        step(1'b1);
        check_val("midconv_digits",  digits16(), 0);
        check_val("midconv_showing", int'(showing), 0);
        check_val("midconv_clk250",  int'(clk_250Hz), 0);
        repeat (PERIOD) step(1'b0);
        check_val("post_rst_4321", digits16(), 'h4321);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0)  score       = 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 39) == 0)  timer       = 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 19) == 0)  alert_val   = 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 59) == 0)  alert_req   = ~alert_req;
            if ($urandom_range(0, 299) == 0) auto_rotate = ~auto_rotate;
            if ($urandom_range(0, 99) == 0)  src_sel     = ~src_sel;
            step($urandom_range(0, 799) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
